// File: rtl/sipo_pkg.sv
// Shared constants, counter-width helper and default counter type for the
// serial-in/parallel-out unit.
package sipo_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 8;

  // A word of at least 2 bits always needs at least a 1-bit counter.
  function automatic int sipo_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int SIPO_DEFAULT_CNT_W = sipo_cnt_width(SIPO_DEFAULT_WIDTH);

  typedef logic [SIPO_DEFAULT_CNT_W-1:0] sipo_cnt_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Word-framing counter: counts ticks modulo WIDTH and emits a one-cycle
// registered pulse on the cycle after the counter wraps.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic wrap_pulse
);

  localparam int CW = sipo_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_reg;
  logic          wrap_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      wrap_reg <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      if (tick) begin
        if (cnt_reg == LAST) begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign wrap_pulse = wrap_reg;

endmodule

// File: rtl/sipo_unit.sv
// Serial-in/parallel-out shift register with optional word framing.
// Define SIPO_VALID_EN to build the bit counter and q_valid pulse.
module sipo_unit
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] q_reg;

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= {data_in, q_reg[WIDTH-1:1]};
      end
    end else begin : g_msb_first
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= {q_reg[WIDTH-2:0], data_in};
      end
    end
  endgenerate

  assign q = q_reg;

`ifdef SIPO_VALID_EN
  // Every clock is a shift, so the counter ticks unconditionally.
  sipo_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk       (clk),
    .reset     (reset),
    .tick      (1'b1),
    .wrap_pulse(q_valid)
  );
`else
  assign q_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_unit.sv
// Scoreboard bench for sipo_unit: both shift directions are driven from one
// stream and checked against a bit-history model of the specification.
module tb_sipo_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] q_lsb, q_msb;
  logic         v_lsb, v_msb;

  int vectors = 0;
  int miscompares = 0;

`ifdef SIPO_VALID_EN
  localparam bit VALID_EN = 1'b1;
`else
  localparam bit VALID_EN = 1'b0;
`endif

  sipo_unit #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .q(q_lsb), .q_valid(v_lsb)
  );

  sipo_unit #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .q(q_msb), .q_valid(v_msb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ql;
    logic [W-1:0] qm;
    logic         v;
  } exp_t;

  exp_t exp_q[$];

  // Model state: bits received since the last reset, newest first.
  logic hist[$];
  int   nbits = 0;
  logic exp_valid_now = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic d);
    exp_t e;
    @(negedge clk);
    reset   = r;
    data_in = d;
    if (r) begin
      hist.delete();
      nbits = 0;
    end else begin
      hist.push_front(d);
      if (hist.size() > W) void'(hist.pop_back());
      nbits++;
    end
    e.ql = '0;
    e.qm = '0;
    for (int k = 0; k < hist.size(); k++) begin
      e.ql[W-1-k] = hist[k];
      e.qm[k]     = hist[k];
    end
    e.v = VALID_EN && !r && (nbits > 0) && (nbits % W == 0);
    exp_valid_now = e.v;
    exp_q.push_back(e);
  endtask

  task automatic drive_byte_lsb(input logic [7:0] b);
    for (int i = 0; i < 8; i++) drive(1'b0, b[i]);
  endtask

  task automatic sample_after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per driven edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (q_lsb !== e.ql || q_msb !== e.qm || v_lsb !== e.v || v_msb !== e.v) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t: q_lsb=%h q_msb=%h v=%b/%b, expected q_lsb=%h q_msb=%h v=%b",
                 $time, q_lsb, q_msb, v_lsb, v_msb, e.ql, e.qm, e.v);
      end
      $display("txn t=%0t reset=%b q_lsb=%h q_msb=%h q_valid=%b", $time, reset, q_lsb, q_msb, v_lsb);
    end
  end

  initial begin
    logic [7:0] stream;
    int guard;

    // Reset, then 1,0,0,1,1,0,0,1 -> 0x99 with a single valid pulse.
    drive(1'b1, 1'b0);
    stream = 8'b1001_1001;
    for (int i = 0; i < 8; i++) drive(1'b0, stream[7-i]);
    sample_after_edge();
    check("word_0x99", q_lsb, 8'h99);
    check("valid_0x99", {7'd0, v_lsb}, {7'd0, VALID_EN});

    // Eight ones, then reset with data_in high clears everything.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
    sample_after_edge();
    check("all_ones", q_lsb, 8'hFF);
    drive(1'b1, 1'b1);
    sample_after_edge();
    check("reset_clears_q", q_lsb, 8'h00);
    check("reset_clears_valid", {7'd0, v_lsb}, 8'h00);

    // Same stream, both directions.
    stream = 8'b1011_0000;
    for (int i = 0; i < 8; i++) drive(1'b0, stream[7-i]);
    sample_after_edge();
    check("dir_msb_first", q_msb, 8'hB0);
    check("dir_lsb_first", q_lsb, 8'h0D);

    // Mid-word reset: the partial word must not shorten the next one.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    drive_byte_lsb(8'hA5);
    sample_after_edge();
    check("midword_word", q_lsb, 8'hA5);
    check("midword_valid", {7'd0, v_lsb}, {7'd0, VALID_EN});

    // Back-to-back words with no gap.
    drive(1'b1, 1'b0);
    drive_byte_lsb(8'h3C);
    sample_after_edge();
    check("b2b_first", q_lsb, 8'h3C);
    check("b2b_first_valid", {7'd0, v_lsb}, {7'd0, VALID_EN});
    drive_byte_lsb(8'hC3);
    sample_after_edge();
    check("b2b_second", q_lsb, 8'hC3);
    check("b2b_second_valid", {7'd0, v_lsb}, {7'd0, VALID_EN});

    // Random stream with occasional resets.
    for (int n = 0; n < 400; n++)
      drive(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sipo_unit.md
SIPO_UNIT -- requirements
Module: sipo_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the parallel output width in bits (minimum 2).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, which sets the shift direction: 1 = new bit enters q[WIDTH-1] and data shifts toward q[0]; 0 = new bit enters q[0] and data shifts toward q[WIDTH-1].
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port data_in, input, 1 bit: the serial data bit, sampled on every rising clk edge.
REQ-006 The block SHALL have port q, output, WIDTH bits: the parallel shift-register contents, driven directly from flops.
REQ-007 The block SHALL have port q_valid, output, 1 bit: a one-cycle pulse that marks a completed WIDTH-bit word.

Function
REQ-008 On each rising edge with reset low, q SHALL shift by one position and capture data_in. With LSB_FIRST=1: q <= {data_in, q[WIDTH-1:1]}. With LSB_FIRST=0: q <= {q[WIDTH-2:0], data_in}.
REQ-009 The block SHALL shift on every clock; there is no enable input.
REQ-010 q SHALL reflect a sampled bit one clock after the sampling edge, with no combinational path from data_in to q.
REQ-011 After WIDTH consecutive shifts, the first bit shifted in SHALL sit in q[0] when LSB_FIRST=1, or in q[WIDTH-1] when LSB_FIRST=0.
REQ-012 A bit counter (0..WIDTH-1) SHALL increment on every non-reset edge and wrap from WIDTH-1 to 0.
REQ-013 q_valid SHALL be high for exactly the one cycle following the edge that captures the WIDTH-th bit (counter wraps), and low otherwise.
REQ-014 q SHALL hold the complete word during the q_valid cycle.
REQ-015 Shifting SHALL continue without a gap after a word completes; bit 1 of the next word SHALL be captured on the edge after the WIDTH-th bit.
REQ-016 If reset is asserted mid-word, the partial word SHALL be discarded, and the counter SHALL restart so that a full WIDTH bits are needed after reset deassertion.
REQ-017 If data_in is X or Z, that value SHALL propagate into q unchanged; the block SHALL NOT substitute a value.

Reset
REQ-018 While reset is high at a rising edge: q <= 0, the counter <= 0, q_valid <= 0.
REQ-019 Reset SHALL take priority over shifting; data_in SHALL be ignored during any reset cycle.
REQ-020 Output values before the first reset edge SHALL be left undefined; reset is the only mechanism for initialisation.

Configuration
REQ-021 The macro SIPO_VALID_EN SHALL control the word-framing feature.
- When defined: the bit counter and the q_valid logic SHALL be compiled in and behave as in REQ-012 to REQ-016.
- When undefined: the counter SHALL be removed, the q_valid port SHALL remain present and be tied to 0, and q behaviour SHALL be unchanged.

Structure
REQ-022 A shared package sipo_pkg SHALL hold:
- the constant SIPO_DEFAULT_WIDTH = 8;
- a function computing the counter width, $clog2(WIDTH);
- a typedef for the bit-counter type.
REQ-023 The counter and q_valid generation SHALL live in one sub-module, sipo_bit_counter (ports clk, reset, tick, wrap_pulse), instantiated only under SIPO_VALID_EN.
REQ-024 The shift register itself SHALL be in the top module, selected by a generate on LSB_FIRST.

Verification
REQ-025 Reset then shift (WIDTH=8, LSB_FIRST=1): reset high for 1 clock, then data_in = 1,0,0,1,1,0,0,1 on consecutive edges -> q = 0x99 after the 8th edge, and q_valid high for exactly that cycle.
REQ-026 Reset clears state: drive 8 ones (q = 0xFF), then assert reset for 1 edge -> q = 0x00 and q_valid = 0 on the next cycle, with data_in held at 1.
REQ-027 Direction (LSB_FIRST=0): shift 1,0,1,1,0,0,0,0 -> q = 0xB0 after 8 edges. With LSB_FIRST=1, the same stream -> q = 0x0D.
REQ-028 Mid-word reset: shift 3 bits, reset 1 edge, shift 8 bits of 0xA5 (LSB first) -> q_valid pulses only after the 8th post-reset bit, and q = 0xA5.
REQ-029 Back-to-back words: 16 continuous bits forming 0x3C then 0xC3 -> q_valid pulses at edges 8 and 16, with q = 0x3C and 0xC3 respectively.
REQ-030 Build without SIPO_VALID_EN: rerun REQ-025 -> q = 0x99 and q_valid stays 0 throughout.
